// File: rtl/rf_pkg.sv
// Shared definitions for the register-file write controller.
//   RF_DW, RF_AW, RF_DEPTH : default data width, register address width and
//                            secondary write-buffer depth (power of 2).
//   rf_entry_t             : one buffered secondary write at the default
//                            widths (target register, data, killed flag).
package rf_pkg;

    localparam int RF_DW    = 32;
    localparam int RF_AW    = 5;
    localparam int RF_DEPTH = 4;

    typedef struct packed {
        logic [RF_AW-1:0] wa;
        logic [RF_DW-1:0] wd;
        logic             killed;
    } rf_entry_t;

endpackage

// File: rtl/rf_wbuf.sv
// Secondary write buffer: a DEPTH-entry FIFO of pending register writes.
//   push_i/push_wa_i/push_wd_i : enqueue one write (caller guarantees !full_o)
//   pop_i                      : dequeue the head (caller guarantees !empty_o)
//   kill_i/kill_wa_i           : mark every live entry targeting kill_wa_i
//   head_*_o                   : oldest entry (address, data, killed flag)
//   empty_o/full_o/pending_o   : occupancy, counting live and killed slots
//   ra1_i/ra2_i -> hitN_o/dataN_o : associative lookup, youngest live match
module rf_wbuf
    import rf_pkg::*;
#(
    parameter int DW    = RF_DW,
    parameter int AW    = RF_AW,
    parameter int DEPTH = RF_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [AW-1:0]            push_wa_i,
    input  logic [DW-1:0]            push_wd_i,
    input  logic                     pop_i,
    input  logic                     kill_i,
    input  logic [AW-1:0]            kill_wa_i,
    input  logic [AW-1:0]            ra1_i,
    input  logic [AW-1:0]            ra2_i,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   pending_o,
    output logic [AW-1:0]            head_wa_o,
    output logic [DW-1:0]            head_wd_o,
    output logic                     head_killed_o,
    output logic                     hit1_o,
    output logic [DW-1:0]            data1_o,
    output logic                     hit2_o,
    output logic [DW-1:0]            data2_o
);

    localparam int PW = $clog2(DEPTH);

    // Data storage carries no reset; valid/kill bits decide what is meaningful.
    logic [AW-1:0]    wa_mem [DEPTH];
    logic [DW-1:0]    wd_mem [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] kill_q;
    logic [PW:0]      wptr_q;
    logic [PW:0]      rptr_q;

    logic [PW-1:0]    widx;
    logic [PW-1:0]    ridx;
    logic [DEPTH-1:0] live;

    assign widx = wptr_q[PW-1:0];
    assign ridx = rptr_q[PW-1:0];
    assign live = valid_q & ~kill_q;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign pending_o     = wptr_q - rptr_q;
    assign empty_o       = (wptr_q == rptr_q);
    assign full_o        = (wptr_q[PW] != rptr_q[PW]) && (widx == ridx);
    assign head_wa_o     = wa_mem[ridx];
    assign head_wd_o     = wd_mem[ridx];
    assign head_killed_o = kill_q[ridx];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            kill_q  <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
        end else begin
            if (kill_i) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (valid_q[i] && (wa_mem[i] == kill_wa_i)) begin
                        kill_q[i] <= 1'b1;
                    end
                end
            end
            if (pop_i) begin
                valid_q[ridx] <= 1'b0;
                rptr_q        <= rptr_q + (PW+1)'(1);
            end
            if (push_i) begin
                valid_q[widx] <= 1'b1;
                kill_q[widx]  <= 1'b0;
                wptr_q        <= wptr_q + (PW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) begin
            wa_mem[widx] <= push_wa_i;
            wd_mem[widx] <= push_wd_i;
        end
    end

    // Walk from oldest to youngest so a later match overrides an earlier one.
    always_comb begin
        logic [PW-1:0] idx;
        idx     = '0;
        hit1_o  = 1'b0;
        data1_o = '0;
        hit2_o  = 1'b0;
        data2_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = ridx + PW'(i);
            if (live[idx] && (wa_mem[idx] == ra1_i)) begin
                hit1_o  = 1'b1;
                data1_o = wd_mem[idx];
            end
            if (live[idx] && (wa_mem[idx] == ra2_i)) begin
                hit2_o  = 1'b1;
                data2_o = wd_mem[idx];
            end
        end
    end

endmodule

// File: rtl/rf_write_ctrl.sv
// Register-file write controller: merges a primary (pipeline writeback)
// write stream with buffered secondary (long-latency) writes onto one
// registered register-file write port, with forwarding of pending writes.
//   clk, rst (async, active low)
//   p_we/p_wa/p_wd            : primary write, always accepted, top priority
//   s_valid/s_wa/s_wd/s_ready : secondary write request, valid/ready handshake
//   we3/wa3/wd3               : registered register-file write port
//   ra1/ra2 -> fwdN_hit/fwdN_data : bypass lookup over port register + buffer
//   pending                   : buffer occupancy (live plus killed slots)
//
// Handshake: a secondary write transfers in any cycle where s_valid and
// s_ready are both 1 at the rising edge; s_ready depends only on occupancy,
// never on s_valid.
module rf_write_ctrl
    import rf_pkg::*;
#(
    parameter int DW    = RF_DW,
    parameter int AW    = RF_AW,
    parameter int DEPTH = RF_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   p_we,
    input  logic [AW-1:0]          p_wa,
    input  logic [DW-1:0]          p_wd,
    input  logic                   s_valid,
    input  logic [AW-1:0]          s_wa,
    input  logic [DW-1:0]          s_wd,
    output logic                   s_ready,
    output logic                   we3,
    output logic [AW-1:0]          wa3,
    output logic [DW-1:0]          wd3,
    input  logic [AW-1:0]          ra1,
    input  logic [AW-1:0]          ra2,
    output logic                   fwd1_hit,
    output logic [DW-1:0]          fwd1_data,
    output logic                   fwd2_hit,
    output logic [DW-1:0]          fwd2_data,
    output logic [$clog2(DEPTH):0] pending
);

    logic          sel_p, s_acc, push, pop, drain_wr;
    logic          empty, full;
    logic [AW-1:0] head_wa;
    logic [DW-1:0] head_wd;
    logic          head_killed;
    logic          bhit1, bhit2;
    logic [DW-1:0] bdata1, bdata2;

    logic          we3_q, we3_d;
    logic [AW-1:0] wa3_q, wa3_d;
    logic [DW-1:0] wd3_q, wd3_d;

    assign sel_p   = p_we && (p_wa != '0);
    assign s_ready = !full;
    assign s_acc   = s_valid && s_ready;
    // A secondary write colliding with a same-cycle primary write is the
    // older of the two, so it is handshaken but never enters the buffer.
    assign push     = s_acc && (s_wa != '0) && !(sel_p && (s_wa == p_wa));
    assign pop      = !sel_p && !empty;
    assign drain_wr = pop && !head_killed;

    rf_wbuf #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) u_wbuf (
        .clk           (clk),
        .rst           (rst),
        .push_i        (push),
        .push_wa_i     (s_wa),
        .push_wd_i     (s_wd),
        .pop_i         (pop),
        .kill_i        (sel_p),
        .kill_wa_i     (p_wa),
        .ra1_i         (ra1),
        .ra2_i         (ra2),
        .empty_o       (empty),
        .full_o        (full),
        .pending_o     (pending),
        .head_wa_o     (head_wa),
        .head_wd_o     (head_wd),
        .head_killed_o (head_killed),
        .hit1_o        (bhit1),
        .data1_o       (bdata1),
        .hit2_o        (bhit2),
        .data2_o       (bdata2)
    );

    always_comb begin
        we3_d = sel_p || drain_wr;
        wa3_d = '0;
        wd3_d = '0;
        if (sel_p) begin
            wa3_d = p_wa;
            wd3_d = p_wd;
        end else if (drain_wr) begin
            wa3_d = head_wa;
            wd3_d = head_wd;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we3_q <= 1'b0;
            wa3_q <= '0;
            wd3_q <= '0;
        end else begin
            we3_q <= we3_d;
            wa3_q <= wa3_d;
            wd3_q <= wd3_d;
        end
    end

    assign we3 = we3_q;
    assign wa3 = wa3_q;
    assign wd3 = wd3_q;

    // The port register is treated as younger than every buffered entry.
    always_comb begin
        fwd1_hit  = 1'b0;
        fwd1_data = '0;
        fwd2_hit  = 1'b0;
        fwd2_data = '0;
        if (ra1 != '0) begin
            if (we3_q && (wa3_q == ra1)) begin
                fwd1_hit  = 1'b1;
                fwd1_data = wd3_q;
            end else if (bhit1) begin
                fwd1_hit  = 1'b1;
                fwd1_data = bdata1;
            end
        end
        if (ra2 != '0) begin
            if (we3_q && (wa3_q == ra2)) begin
                fwd2_hit  = 1'b1;
                fwd2_data = wd3_q;
            end else if (bhit2) begin
                fwd2_hit  = 1'b1;
                fwd2_data = bdata2;
            end
        end
    end

endmodule

// File: tb/tb_rf_write_ctrl.sv
// Bench for rf_write_ctrl: directed vectors, expected port writes queued in
// exp_q and checked by an independent monitor on every we3 pulse.
module tb_rf_write_ctrl;
    import rf_pkg::*;

    localparam int DW    = RF_DW;
    localparam int AW    = RF_AW;
    localparam int DEPTH = RF_DEPTH;

    logic                   clk, rst;
    logic                   p_we, s_valid, s_ready, we3;
    logic [AW-1:0]          p_wa, s_wa, wa3, ra1, ra2;
    logic [DW-1:0]          p_wd, s_wd, wd3;
    logic                   fwd1_hit, fwd2_hit;
    logic [DW-1:0]          fwd1_data, fwd2_data;
    logic [$clog2(DEPTH):0] pending;

    logic [AW+DW-1:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    rf_write_ctrl #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .p_we(p_we), .p_wa(p_wa), .p_wd(p_wd),
        .s_valid(s_valid), .s_wa(s_wa), .s_wd(s_wd), .s_ready(s_ready),
        .we3(we3), .wa3(wa3), .wd3(wd3),
        .ra1(ra1), .ra2(ra2),
        .fwd1_hit(fwd1_hit), .fwd1_data(fwd1_data),
        .fwd2_hit(fwd2_hit), .fwd2_data(fwd2_data),
        .pending(pending)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // driver tasks
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic idle();
        p_we = 1'b0; p_wa = '0; p_wd = '0;
        s_valid = 1'b0; s_wa = '0; s_wd = '0;
    endtask

    task automatic prim(input logic [AW-1:0] a, input logic [DW-1:0] d);
        p_we = 1'b1; p_wa = a; p_wd = d;
    endtask

    task automatic sec(input logic [AW-1:0] a, input logic [DW-1:0] d);
        s_valid = 1'b1; s_wa = a; s_wd = d;
    endtask

    task automatic push_exp(input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_q.push_back({a, d});
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (rst && we3) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_write: got wa3=%0d wd3=0x%0h expected no write", wa3, wd3);
            end else begin
                logic [AW+DW-1:0] e;
                e = exp_q.pop_front();
                chk("port_write", {wa3, wd3}, e);
            end
        end
    end

    initial begin
        idle();
        ra1 = '0; ra2 = '0;
        rst = 1'b0;
        cyc(); cyc();
        chk("rst_we3", we3, 0);
        chk("rst_pending", pending, 0);
        chk("rst_s_ready", s_ready, 1);
        chk("rst_wa3", wa3, 0);
        rst = 1'b1;
        cyc();

        // single primary write, one-cycle pulse
        push_exp(3, 'h11);
        prim(3, 'h11);
        cyc();
        chk("t1_we3", we3, 1);
        chk("t1_wa3", wa3, 3);
        chk("t1_wd3", wd3, 'h11);
        idle();
        cyc();
        chk("t1_we3_one_cycle", we3, 0);

        // fill buffer under primary pressure, then drain in order
        for (int i = 0; i < 5; i++) push_exp(8, 'h80 + i);
        for (int i = 0; i < 4; i++) push_exp(4 + i, 'h40 + i);
        for (int i = 0; i < 4; i++) begin
            prim(8, 'h80 + i);
            sec(4 + i, 'h40 + i);
            cyc();
        end
        chk("t2_pending_full", pending, 4);
        chk("t2_s_ready_full", s_ready, 0);
        ra1 = 6; ra2 = 8;
        #1;
        chk("t2_fwd1_hit", fwd1_hit, 1);
        chk("t2_fwd1_data", fwd1_data, 'h42);
        chk("t2_fwd2_data_portreg", fwd2_data, 'h83);
        ra1 = '0; ra2 = '0;
        prim(8, 'h84);
        sec(9, 'h99);   // not accepted: buffer full
        cyc();
        chk("t2_pending_still_full", pending, 4);
        idle();
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("t2_drain_we3", we3, 1);
            chk("t2_drain_wa3", wa3, 4 + i);
            if (i == 0) begin
                chk("t2_pending_after_pop", pending, 3);
                chk("t2_s_ready_after_pop", s_ready, 1);
            end
        end
        chk("t2_pending_empty", pending, 0);

        // primary kills an older buffered write to the same register
        push_exp(5, 'hBB);
        sec(5, 'hAA);
        cyc();
        chk("t3_pending_buffered", pending, 1);
        chk("t3_no_we3", we3, 0);
        idle();
        prim(5, 'hBB);
        ra1 = 5;
        cyc();
        chk("t3_pending_killed_slot", pending, 1);
        chk("t3_fwd1_hit", fwd1_hit, 1);
        chk("t3_fwd1_data", fwd1_data, 'hBB);
        idle();
        cyc();
        chk("t3_killed_pop_no_we3", we3, 0);
        chk("t3_pending_after_pop", pending, 0);
        chk("t3_fwd1_no_hit", fwd1_hit, 0);
        ra1 = '0;

        // same-cycle collision: secondary is older and is discarded
        push_exp(9, 1);
        prim(9, 1);
        sec(9, 2);
        cyc();
        chk("t4_pending", pending, 0);
        chk("t4_wd3", wd3, 1);
        idle();
        cyc();
        chk("t4_no_second_write", we3, 0);

        // writes to register 0 are dropped
        prim(0, 'h55);
        sec(0, 'h66);
        cyc();
        chk("t5_r0_no_we3", we3, 0);
        chk("t5_r0_no_push", pending, 0);
        idle();
        cyc();

        // forwarding picks the youngest buffered match
        push_exp(8, 'h90); push_exp(8, 'h91);
        push_exp(7, 'h5);  push_exp(7, 'h6);
        prim(8, 'h90); sec(7, 'h5);
        cyc();
        prim(8, 'h91); sec(7, 'h6);
        cyc();
        ra1 = 7; ra2 = 0;
        #1;
        chk("t6_fwd1_hit", fwd1_hit, 1);
        chk("t6_fwd1_data", fwd1_data, 'h6);
        chk("t6_fwd2_hit_r0", fwd2_hit, 0);
        chk("t6_fwd2_data_r0", fwd2_data, 0);
        ra1 = '0;
        idle();
        cyc(); cyc();
        cyc();
        chk("t6_pending_drained", pending, 0);

        // reset mid-operation discards buffered writes
        for (int i = 0; i < 3; i++) begin
            push_exp(8, 'hA0 + i);
            prim(8, 'hA0 + i);
            sec(10 + i, 'hC0 + i);
            cyc();
        end
        chk("t7_pending_pre", pending, 3);
        idle();
        #2 rst = 1'b0;
        #1;
        chk("t7_rst_we3", we3, 0);
        chk("t7_rst_wd3", wd3, 0);
        chk("t7_rst_pending", pending, 0);
        chk("t7_rst_s_ready", s_ready, 1);
        cyc();
        rst = 1'b1;
        for (int i = 0; i < 6; i++) cyc();
        chk("t7_pending_after_release", pending, 0);
        chk("t7_no_we3_after_release", we3, 0);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
